// File: rtl/mcu_param_core.sv
// Parametrised accumulator MCU core: INIT/FETCH/EXEC/HALT controller with PC, IR,
// register file, ALU, accumulator and registered Z/C flags. Fetch uses a req/valid handshake.
module mcu_param_core #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8,
    parameter int OPD_W  = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [PC_W-1:0]     resetPC,
    output logic [PC_W-1:0]     currentPC,
    output logic                instr_req,
    input  logic                instr_valid,
    input  logic [OPD_W+3:0]    instr_data,
    output logic [DATA_W-1:0]   acc_out,
    output logic                flag_z,
    output logic                flag_c,
    output logic                halted
);

    localparam int NREG = 1 << OPD_W;

    typedef enum logic [1:0] {S_INIT, S_FETCH, S_EXEC, S_HALT} state_t;

    state_t              r_state, w_nextState;
    logic [PC_W-1:0]     r_pc, w_nextPc;
    logic [OPD_W+3:0]    r_ir;
    logic [DATA_W-1:0]   r_acc, w_nextAcc;
    logic                r_z, r_c, w_nextZ, w_nextC;
    logic                w_regWe, w_accWr;
    logic [DATA_W-1:0]   r_regs [NREG];

    logic [3:0]          w_opcode;
    logic [OPD_W-1:0]    w_opd;
    logic [DATA_W-1:0]   w_r;
    logic [DATA_W:0]     w_sum, w_diff;
    logic                w_handshake;

    assign w_opcode    = r_ir[OPD_W+3:OPD_W];
    assign w_opd       = r_ir[OPD_W-1:0];
    assign w_r         = r_regs[w_opd];
    assign w_sum       = {1'b0, r_acc} + {1'b0, w_r};
    assign w_diff      = {1'b0, r_acc} - {1'b0, w_r};
    assign w_handshake = (r_state == S_FETCH) && instr_valid;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_INIT:  w_nextState = S_FETCH;
            S_FETCH: if (instr_valid) w_nextState = S_EXEC;
            S_EXEC:  w_nextState = (w_opcode == 4'hF) ? S_HALT : S_FETCH;
            default: w_nextState = S_HALT;
        endcase
    end

    // Datapath: a jump in EXEC simply replaces the PC already incremented during FETCH
    always_comb begin
        w_nextPc  = r_pc;
        w_nextAcc = r_acc;
        w_nextZ   = r_z;
        w_nextC   = r_c;
        w_regWe   = 1'b0;
        w_accWr   = 1'b0;
        case (r_state)
            S_INIT:  w_nextPc = resetPC;
            S_FETCH: if (instr_valid) w_nextPc = r_pc + PC_W'(1);
            S_EXEC: begin
                case (w_opcode)
                    4'h1: begin w_nextAcc = DATA_W'(w_opd); w_accWr = 1'b1; end
                    4'h2: begin w_nextAcc = w_r; w_accWr = 1'b1; end
                    4'h3: w_regWe = 1'b1;
                    4'h4: begin w_nextAcc = w_sum[DATA_W-1:0]; w_nextC = w_sum[DATA_W]; w_accWr = 1'b1; end
                    4'h5: begin w_nextAcc = w_diff[DATA_W-1:0]; w_nextC = w_diff[DATA_W]; w_accWr = 1'b1; end
                    4'h6: begin w_nextAcc = r_acc & w_r; w_accWr = 1'b1; end
                    4'h7: begin w_nextAcc = r_acc | w_r; w_accWr = 1'b1; end
                    4'h8: begin w_nextAcc = r_acc ^ w_r; w_accWr = 1'b1; end
                    4'h9: begin w_nextAcc = ~r_acc; w_accWr = 1'b1; end
                    4'hA: begin w_nextC = r_acc[DATA_W-1]; w_nextAcc = r_acc << 1; w_accWr = 1'b1; end
                    4'hB: begin w_nextC = r_acc[0]; w_nextAcc = r_acc >> 1; w_accWr = 1'b1; end
                    4'hC: w_nextPc = PC_W'(w_opd);
                    4'hD: w_nextPc = PC_W'(w_r);
                    4'hE: if (r_z) w_nextPc = PC_W'(w_opd);
                    default: ;
                endcase
                if (w_accWr) w_nextZ = (w_nextAcc == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_INIT;
            r_pc    <= '0;
            r_ir    <= '0;
            r_acc   <= '0;
            r_z     <= 1'b0;
            r_c     <= 1'b0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            r_state <= w_nextState;
            r_pc    <= w_nextPc;
            r_acc   <= w_nextAcc;
            r_z     <= w_nextZ;
            r_c     <= w_nextC;
            if (w_handshake) r_ir <= instr_data;
            if (w_regWe) r_regs[w_opd] <= r_acc;
        end
    end

    assign currentPC = r_pc;
    assign instr_req = (r_state == S_FETCH);
    assign acc_out   = r_acc;
    assign flag_z    = r_z;
    assign flag_c    = r_c;
    assign halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_mcu_param_core.sv
// Directed self-checking bench for mcu_param_core: default 8/8/4 instance plus a 16/10/5 instance.
module tb_mcu_param_core;

    logic       Clk;
    logic       resetN, resetW;
    logic [7:0] pcN;
    logic [7:0] currentPCN;
    logic       reqN, validN;
    logic [7:0] instrN;
    logic [7:0] accN;
    logic       zN, cN, haltN;
    logic [7:0] memN [256];

    logic [9:0]  pcW;
    logic [9:0]  currentPCW;
    logic        reqW, validW;
    logic [8:0]  instrW;
    logic [15:0] accW;
    logic        zW, cW, haltW;
    logic [8:0]  memW [1024];

    int checks = 0;
    int errors = 0;

    assign instrN = memN[currentPCN];
    assign instrW = memW[currentPCW];

    mcu_param_core u_dut (
        .Clk(Clk), .Reset(resetN), .resetPC(pcN), .currentPC(currentPCN),
        .instr_req(reqN), .instr_valid(validN), .instr_data(instrN),
        .acc_out(accN), .flag_z(zN), .flag_c(cN), .halted(haltN)
    );

    mcu_param_core #(.DATA_W(16), .PC_W(10), .OPD_W(5)) u_wide (
        .Clk(Clk), .Reset(resetW), .resetPC(pcW), .currentPC(currentPCW),
        .instr_req(reqW), .instr_valid(validW), .instr_data(instrW),
        .acc_out(accW), .flag_z(zW), .flag_c(cW), .halted(haltW)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic doReset(input logic [7:0] startPc);
        pcN = startPc;
        validN = 1'b1;
        resetN = 1'b1;
        tick(1);
        resetN = 1'b0;
        tick(1);
    endtask

    task automatic test_reset;
        memN[8'h10] = 8'h15;
        pcN = 8'h10;
        validN = 1'b1;
        resetN = 1'b1;
        tick(1);
        checks++; if (currentPCN !== 8'h00) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 00", currentPCN); end
        checks++; if ({reqN, zN, cN, haltN} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ctl: got %b expected 0000", {reqN, zN, cN, haltN}); end
        checks++; if (accN !== 8'h00) begin errors++; $display("[TB] FAIL reset_acc: got %h expected 00", accN); end
        resetN = 1'b0;
        tick(1);
        checks++; if (currentPCN !== 8'h10) begin errors++; $display("[TB] FAIL init_pc: got %h expected 10", currentPCN); end
        checks++; if (reqN !== 1'b1) begin errors++; $display("[TB] FAIL init_req: got %b expected 1", reqN); end
        tick(1);
        checks++; if ({currentPCN, reqN} !== {8'h11, 1'b0}) begin errors++; $display("[TB] FAIL exec_pc_req: got %h/%b expected 11/0", currentPCN, reqN); end
        tick(1);
        checks++; if ({accN, currentPCN} !== {8'h05, 8'h11}) begin errors++; $display("[TB] FAIL first_ldi: got acc %h pc %h expected 05/11", accN, currentPCN); end
    endtask

    task automatic test_add_sequence;
        memN[0] = 8'h15; memN[1] = 8'h33; memN[2] = 8'h17; memN[3] = 8'h43; memN[4] = 8'h23;
        doReset(8'h00);
        tick(7);
        checks++; if (accN !== 8'h07) begin errors++; $display("[TB] FAIL add_before: got %h expected 07", accN); end
        tick(1);
        checks++; if ({accN, zN, cN} !== {8'h0C, 2'b00}) begin errors++; $display("[TB] FAIL add_result: got %h z%b c%b expected 0c z0 c0", accN, zN, cN); end
        checks++; if ({currentPCN, reqN} !== {8'h04, 1'b1}) begin errors++; $display("[TB] FAIL add_timing: got %h/%b expected 04/1", currentPCN, reqN); end
        tick(2);
        checks++; if (accN !== 8'h05) begin errors++; $display("[TB] FAIL ldr_r3: got %h expected 05", accN); end
    endtask

    task automatic test_shift_carry;
        memN[8'h20] = 8'h1F;
        for (int i = 1; i <= 4; i++) memN[8'h20 + i] = 8'hA0;
        memN[8'h25] = 8'h31; memN[8'h26] = 8'h41; memN[8'h27] = 8'h51;
        doReset(8'h20);
        tick(10);
        checks++; if ({accN, cN} !== {8'hF0, 1'b0}) begin errors++; $display("[TB] FAIL shl4: got %h c%b expected f0 c0", accN, cN); end
        tick(4);
        checks++; if ({accN, cN, zN} !== {8'hE0, 2'b10}) begin errors++; $display("[TB] FAIL add_carry: got %h c%b z%b expected e0 c1 z0", accN, cN, zN); end
        tick(2);
        checks++; if ({accN, cN} !== {8'hF0, 1'b1}) begin errors++; $display("[TB] FAIL sub_borrow: got %h c%b expected f0 c1", accN, cN); end
    endtask

    task automatic test_jz_wrap;
        memN[8'h30] = 8'h19; memN[8'h31] = 8'h32; memN[8'h32] = 8'h52; memN[8'h33] = 8'hE4;
        memN[4] = 8'h11; memN[5] = 8'hE8; memN[6] = 8'h10; memN[7] = 8'h90;
        memN[8] = 8'h35; memN[9] = 8'hD5; memN[8'hFF] = 8'h00;
        doReset(8'h30);
        tick(6);
        checks++; if ({accN, zN, cN} !== {8'h00, 2'b10}) begin errors++; $display("[TB] FAIL sub_zero: got %h z%b c%b expected 00 z1 c0", accN, zN, cN); end
        tick(2);
        checks++; if (currentPCN !== 8'h04) begin errors++; $display("[TB] FAIL jz_taken: got %h expected 04", currentPCN); end
        tick(2);
        checks++; if ({accN, zN} !== {8'h01, 1'b0}) begin errors++; $display("[TB] FAIL ldi1: got %h z%b expected 01 z0", accN, zN); end
        tick(2);
        checks++; if (currentPCN !== 8'h06) begin errors++; $display("[TB] FAIL jz_fall: got %h expected 06", currentPCN); end
        tick(8);
        checks++; if (currentPCN !== 8'hFF) begin errors++; $display("[TB] FAIL jmpr: got %h expected ff", currentPCN); end
        tick(1);
        checks++; if (currentPCN !== 8'h00) begin errors++; $display("[TB] FAIL pc_wrap: got %h expected 00", currentPCN); end
    endtask

    task automatic test_wait_states;
        memN[8'h40] = 8'h13; memN[8'h41] = 8'h1A; memN[8'h42] = 8'h1C;
        doReset(8'h40);
        tick(2);
        validN = 1'b0;
        tick(3);
        checks++; if ({currentPCN, accN, reqN, zN, cN} !== {8'h41, 8'h03, 3'b100}) begin errors++; $display("[TB] FAIL wait_hold: got pc %h acc %h req%b z%b c%b expected 41 03 1 0 0", currentPCN, accN, reqN, zN, cN); end
        validN = 1'b1;
        tick(1);
        checks++; if ({currentPCN, reqN} !== {8'h42, 1'b0}) begin errors++; $display("[TB] FAIL wait_handshake: got %h/%b expected 42/0", currentPCN, reqN); end
        tick(1);
        checks++; if (accN !== 8'h0A) begin errors++; $display("[TB] FAIL wait_exec: got %h expected 0a", accN); end
        validN = 1'b0;
        tick(2);
        validN = 1'b1;
        resetN = 1'b1;
        #1;
        checks++; if ({currentPCN, accN, reqN, zN, cN, haltN} !== {8'h00, 8'h00, 4'b0000}) begin errors++; $display("[TB] FAIL mid_reset: got pc %h acc %h req%b z%b c%b h%b expected all zero", currentPCN, accN, reqN, zN, cN, haltN); end
        tick(1);
        resetN = 1'b0;
    endtask

    task automatic test_halt;
        memN[8'h50] = 8'h16; memN[8'h51] = 8'hF0; memN[8'h52] = 8'h11;
        doReset(8'h50);
        tick(4);
        checks++; if ({haltN, reqN, currentPCN} !== {2'b10, 8'h52}) begin errors++; $display("[TB] FAIL halt_enter: got h%b req%b pc %h expected 1 0 52", haltN, reqN, currentPCN); end
        tick(10);
        checks++; if ({haltN, reqN, currentPCN, accN} !== {2'b10, 8'h52, 8'h06}) begin errors++; $display("[TB] FAIL halt_frozen: got h%b req%b pc %h acc %h expected 1 0 52 06", haltN, reqN, currentPCN, accN); end
        resetN = 1'b1;
        #1;
        checks++; if (haltN !== 1'b0) begin errors++; $display("[TB] FAIL halt_reset: got %b expected 0", haltN); end
        tick(1);
        resetN = 1'b0;
        tick(1);
        checks++; if ({currentPCN, reqN} !== {8'h50, 1'b1}) begin errors++; $display("[TB] FAIL halt_recover: got %h/%b expected 50/1", currentPCN, reqN); end
    endtask

    task automatic test_wide;
        memW[10'h200] = 9'h025; memW[10'h201] = 9'h063; memW[10'h202] = 9'h027; memW[10'h203] = 9'h083;
        memW[10'h204] = 9'h020; memW[10'h205] = 9'h120; memW[10'h206] = 9'h063;
        memW[10'h207] = 9'h021; memW[10'h208] = 9'h083;
        pcW = 10'h200;
        validW = 1'b1;
        resetW = 1'b1;
        tick(1);
        resetW = 1'b0;
        tick(1);
        checks++; if (currentPCW !== 10'h200) begin errors++; $display("[TB] FAIL wide_init: got %h expected 200", currentPCW); end
        tick(8);
        checks++; if ({accW, zW, cW} !== {16'h000C, 2'b00}) begin errors++; $display("[TB] FAIL wide_add: got %h z%b c%b expected 000c z0 c0", accW, zW, cW); end
        tick(4);
        checks++; if (accW !== 16'hFFFF) begin errors++; $display("[TB] FAIL wide_not: got %h expected ffff", accW); end
        tick(6);
        checks++; if ({accW, zW, cW} !== {16'h0000, 2'b11}) begin errors++; $display("[TB] FAIL wide_overflow: got %h z%b c%b expected 0000 z1 c1", accW, zW, cW); end
        checks++; if (currentPCW !== 10'h209) begin errors++; $display("[TB] FAIL wide_pc: got %h expected 209", currentPCW); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) memN[i] = 8'h00;
        for (int i = 0; i < 1024; i++) memW[i] = 9'h000;
        resetN = 1'b1;
        resetW = 1'b1;
        validN = 1'b0;
        validW = 1'b0;
        pcN = 8'h00;
        pcW = 10'h000;
        tick(1);
        test_reset;
        test_add_sequence;
        test_shift_carry;
        test_jz_wrap;
        test_wait_states;
        test_halt;
        test_wide;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
